// File: rtl/synch_down.sv
// Synchronous down counter with prescaler, start/stop/load control and a wrap strobe.
// Define SYNCH_DOWN_AUTORELOAD_EN to wrap from 0 to the last loaded value instead of all-ones.
module synch_down #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc,
  output logic             busy
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state_q;
  logic [PW-1:0]    pre_q;
  logic [WIDTH-1:0] count_q;
  logic             zero_q;
  logic             tc_q;
  logic             busy_q;

  logic             tick_d;
  logic [WIDTH-1:0] wrap_val_d;
  logic [WIDTH-1:0] count_step_d;

`ifdef SYNCH_DOWN_AUTORELOAD_EN
  logic [WIDTH-1:0] rld_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rld_q <= '0;
    end else if (load) begin
      rld_q <= load_val;
    end
  end

  assign wrap_val_d = rld_q;
`else
  assign wrap_val_d = '1;
`endif

  // A tick is suppressed by load or stop on the same edge.
  assign tick_d       = (state_q == RUN) && !load && !stop && (pre_q == PRE_LAST);
  assign count_step_d = (count_q == '0) ? wrap_val_d : count_q - 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      count_q <= '0;
      zero_q  <= 1'b1;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else if (load) begin
      state_q <= IDLE;
      pre_q   <= '0;
      count_q <= load_val;
      zero_q  <= (load_val == '0);
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q <= RUN;
            pre_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= HOLD;
            busy_q  <= 1'b0;
          end else if (tick_d) begin
            pre_q   <= '0;
            count_q <= count_step_d;
            zero_q  <= (count_step_d == '0);
            tc_q    <= (count_q == '0);
          end else begin
            pre_q <= pre_q + 1'b1;
          end
        end
        HOLD: begin
          // Prescaler is left untouched so the step phase survives the pause.
          if (start && !stop) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count = count_q;
  assign zero  = zero_q;
  assign tc    = tc_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_synch_down.sv
// Scoreboard bench for synch_down: WIDTH=4/DIV=3 and WIDTH=2/DIV=1 instances.
// Stimulus pushes expected {count,zero,tc,busy} per cycle; a monitor pops and compares.
module tb_synch_down;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic       a_start = 0, a_stop = 0, a_load = 0;
  logic [3:0] a_load_val = '0;
  logic [3:0] a_count;
  logic       a_zero, a_tc, a_busy;

  logic       b_start = 0, b_stop = 0, b_load = 0;
  logic [1:0] b_load_val = '0;
  logic [1:0] b_count;
  logic       b_zero, b_tc, b_busy;

  synch_down #(.WIDTH(4), .DIV(3)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(a_start), .stop(a_stop), .load(a_load),
    .load_val(a_load_val), .count(a_count), .zero(a_zero), .tc(a_tc), .busy(a_busy)
  );

  synch_down #(.WIDTH(2), .DIV(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(b_start), .stop(b_stop), .load(b_load),
    .load_val(b_load_val), .count(b_count), .zero(b_zero), .tc(b_tc), .busy(b_busy)
  );

`ifdef SYNCH_DOWN_AUTORELOAD_EN
  localparam logic [3:0] A_WRAP = 4'd5;
`else
  localparam logic [3:0] A_WRAP = 4'd15;
`endif

  typedef struct {
    int         cyc;
    bit         is_b;
    string      name;
    logic [6:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] act_a();
    return {a_count, a_zero, a_tc, a_busy};
  endfunction

  function automatic logic [6:0] act_b();
    return {2'b00, b_count, b_zero, b_tc, b_busy};
  endfunction

  task automatic chk(string nm, logic [6:0] act, logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got count=%0d zero=%b tc=%b busy=%b, expected count=%0d zero=%b tc=%b busy=%b",
               nm, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
    end else begin
      $display("ok   %s: count=%0d zero=%b tc=%b busy=%b", nm, act[6:3], act[2], act[1], act[0]);
    end
  endtask

  // Monitor: compares every expectation due at this falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s: expectation for cycle %0d not compared (now %0d)", e.name, e.cyc, cyc);
        end else begin
          chk(e.name, e.is_b ? act_b() : act_a(), e.exp);
        end
      end
    end
  end

  task automatic step_a(bit st, bit sp, bit ld, logic [3:0] lv, string nm,
                        logic [3:0] c, bit z, bit t, bit bz);
    @(negedge clk);
    a_start = st; a_stop = sp; a_load = ld; a_load_val = lv;
    sb.push_back('{cyc + 1, 1'b0, nm, {c, z, t, bz}});
  endtask

  task automatic step_b(bit st, bit sp, bit ld, logic [1:0] lv, string nm,
                        logic [1:0] c, bit z, bit t, bit bz);
    @(negedge clk);
    b_start = st; b_stop = sp; b_load = ld; b_load_val = lv;
    sb.push_back('{cyc + 1, 1'b1, nm, {2'b00, c, z, t, bz}});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] c;
    logic [1:0] bseq [6];
    bit         btc [6];

    // Power-up reset
    #3 reset_n = 1'b0;
    #1;
    chk("reset_a", act_a(), {4'd0, 1'b1, 1'b0, 1'b0});
    chk("reset_b", act_b(), {2'd0, 2'd0, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    reset_n = 1'b1;

    // Basic count from 5, then wrap
    step_a(0, 0, 1, 4'd5, "load5", 4'd5, 0, 0, 0);
    step_a(1, 0, 0, 4'd0, "start", 4'd5, 0, 0, 1);
    for (int k = 1; k <= 19; k++) begin
      if (k < 18) begin
        c = 4'(5 - k / 3);
        step_a(0, 0, 0, 4'd0, $sformatf("count_k%0d", k), c, (c == 0), 0, 1);
      end else begin
        step_a(0, 0, 0, 4'd0, $sformatf("wrap_k%0d", k), A_WRAP, 0, (k == 18), 1);
      end
    end

    // Pause with frozen prescaler (pre=1), hold for 10 cycles
    step_a(0, 0, 1, 4'd9, "load9", 4'd9, 0, 0, 0);
    step_a(1, 0, 0, 4'd0, "start9", 4'd9, 0, 0, 1);
    for (int k = 1; k <= 7; k++)
      step_a(0, 0, 0, 4'd0, $sformatf("p_k%0d", k), 4'(9 - k / 3), 0, 0, 1);
    step_a(0, 1, 0, 4'd0, "stop", 4'd7, 0, 0, 0);
    for (int k = 1; k <= 9; k++)
      step_a(0, 0, 0, 4'd0, $sformatf("hold_%0d", k), 4'd7, 0, 0, 0);
    step_a(1, 0, 0, 4'd0, "resume", 4'd7, 0, 0, 1);
    step_a(0, 0, 0, 4'd0, "resume_1", 4'd7, 0, 0, 1);
    step_a(0, 0, 0, 4'd0, "resume_dec", 4'd6, 0, 0, 1);

    // Stop coinciding with a tick edge
    step_a(0, 0, 0, 4'd0, "pre1", 4'd6, 0, 0, 1);
    step_a(0, 0, 0, 4'd0, "pre2", 4'd6, 0, 0, 1);
    step_a(0, 1, 0, 4'd0, "stop_on_tick", 4'd6, 0, 0, 0);
    step_a(1, 0, 0, 4'd0, "resume2", 4'd6, 0, 0, 1);
    step_a(0, 0, 0, 4'd0, "tick_after_resume", 4'd5, 0, 0, 1);

    // Load wins over a coinciding tick and start
    step_a(0, 0, 0, 4'd0, "pre1b", 4'd5, 0, 0, 1);
    step_a(0, 0, 0, 4'd0, "pre2b", 4'd5, 0, 0, 1);
    step_a(1, 0, 1, 4'd12, "load12_on_tick", 4'd12, 0, 0, 0);

    // Load wins over a coinciding wrap tick: no tc
    step_a(0, 0, 1, 4'd0, "load0", 4'd0, 1, 0, 0);
    step_a(1, 0, 0, 4'd0, "start0", 4'd0, 1, 0, 1);
    step_a(0, 0, 0, 4'd0, "z_pre1", 4'd0, 1, 0, 1);
    step_a(0, 0, 0, 4'd0, "z_pre2", 4'd0, 1, 0, 1);
    step_a(1, 0, 1, 4'd3, "load3_on_wrap", 4'd3, 0, 0, 0);

    // start+stop in RUN and HOLD, start held in RUN
    step_a(1, 0, 0, 4'd0, "start3", 4'd3, 0, 0, 1);
    step_a(1, 1, 0, 4'd0, "startstop_run", 4'd3, 0, 0, 0);
    step_a(1, 1, 0, 4'd0, "startstop_hold", 4'd3, 0, 0, 0);
    step_a(1, 0, 0, 4'd0, "resume3", 4'd3, 0, 0, 1);
    step_a(1, 0, 0, 4'd0, "run_start_1", 4'd3, 0, 0, 1);
    step_a(1, 0, 0, 4'd0, "run_start_2", 4'd3, 0, 0, 1);
    step_a(1, 0, 0, 4'd0, "run_start_dec", 4'd2, 0, 0, 1);

    // stop alone in IDLE is ignored
    step_a(0, 0, 1, 4'd3, "load3", 4'd3, 0, 0, 0);
    step_a(0, 1, 0, 4'd0, "stop_idle", 4'd3, 0, 0, 0);
    step_a(1, 0, 0, 4'd0, "start_idle", 4'd3, 0, 0, 1);

    // Mid-run setup for asynchronous reset
    step_a(0, 0, 1, 4'd5, "load5r", 4'd5, 0, 0, 0);
    step_a(1, 0, 0, 4'd0, "start5r", 4'd5, 0, 0, 1);
    step_a(0, 0, 0, 4'd0, "run5r", 4'd5, 0, 0, 1);
    @(negedge clk);
    a_start = 0; a_stop = 0; a_load = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_a", act_a(), {4'd0, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    reset_n = 1'b1;

    // WIDTH=2, DIV=1: wrap from 0 with a tick every clock
`ifdef SYNCH_DOWN_AUTORELOAD_EN
    bseq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    btc  = '{1, 1, 1, 1, 1, 1};
`else
    bseq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};
    btc  = '{1, 0, 0, 0, 1, 0};
`endif
    step_b(0, 0, 1, 2'd0, "b_load0", 2'd0, 1, 0, 0);
    step_b(1, 0, 0, 2'd0, "b_start", 2'd0, 1, 0, 1);
    for (int k = 0; k < 6; k++)
      step_b(0, 0, 0, 2'd0, $sformatf("b_step%0d", k + 1), bseq[k], (bseq[k] == 2'd0), btc[k], 1);
    step_b(0, 0, 1, 2'd1, "b_load1", 2'd1, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left uncompared, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
